// File: rtl/seg_pkg.sv
// Shared constants for the 4-digit seven-segment scan driver.
// Holds the active-low hex glyph table, the all-off pattern and the
// digit-slot to anode one-hot table.
package seg_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned SEG_W    = 7;
  localparam int unsigned AN_W     = 4;
  localparam int unsigned IDX_W    = 2;

  // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [SEG_W-1:0] HEX_SEG_LOW [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

  localparam logic [SEG_W-1:0] SEG_OFF_LOW = 7'h7F;

  // Slot 0 is the leftmost digit (an[3]); anodes are active-low.
  localparam logic [AN_W-1:0] AN_ONEHOT [4] = '{
    4'b0111, 4'b1011, 4'b1101, 4'b1110
  };

  localparam logic [AN_W-1:0] AN_NONE = 4'b1111;

endpackage

// File: rtl/seg_scan_driver_hex7seg.sv
// Combinational hex-to-seven-segment decoder, active-low output.
// Ports: hex (4-bit nibble in), seg_c (7-bit {g,f,e,d,c,b,a}, active-low).
module hex7seg
  import seg_pkg::*;
(
  input  logic [NIBBLE_W-1:0] hex,
  output logic [SEG_W-1:0]    seg_c
);

  assign seg_c = HEX_SEG_LOW[hex];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a 4-digit seven-segment display showing
// two bytes as four hex digits, with frame-coherent snapshot, hold,
// leading-zero blanking and a separator decimal point.
// Ports:
//   clk2        clock
//   reset       asynchronous active-low reset
//   num1, num2  display bytes (num1 on the left two digits)
//   hold        freeze the snapshot at frame wrap
//   blank_lz    blank zero high nibbles
//   dp_en       light the decimal point after digit 1
//   an          registered anode select, one-hot active-low
//   seg, dp     registered segment / decimal-point drive
//   frame_done  registered one-cycle pulse at each frame wrap
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
)(
  input  logic             clk2,
  input  logic             reset,
  input  logic [7:0]       num1,
  input  logic [7:0]       num2,
  input  logic             hold,
  input  logic             blank_lz,
  input  logic             dp_en,
  output logic [AN_W-1:0]  an,
  output logic [SEG_W-1:0] seg,
  output logic             dp,
  output logic             frame_done
);

  localparam int unsigned CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned SNAP_W = 16;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLK_DIV - 1);
  localparam logic [SEG_W-1:0] SEG_OFF_OUT = SEG_ACTIVE_LOW ? SEG_OFF_LOW : ~SEG_OFF_LOW;
  localparam logic             DP_OFF_OUT  = SEG_ACTIVE_LOW;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SNAP_W-1:0]   snap_q, snap_d;
  logic                tick_c, wrap_c;
  logic [NIBBLE_W-1:0] nibble_c;
  logic [SEG_W-1:0]    hex_c, seg_low_c, seg_out_c;
  logic                dp_on_c, dp_out_c;

  hex7seg u_hex7seg (
    .hex   (nibble_c),
    .seg_c (hex_c)
  );

  // Next-state and next-output computation. Output values are built from the
  // post-edge slot index and snapshot so the new digit appears on the same
  // edge that advances idx (and, at wrap, loads the snapshot).
  always_comb begin
    tick_c    = (cnt_q == CNT_LAST);
    cnt_d     = tick_c ? '0 : cnt_q + CNT_W'(1);
    wrap_c    = tick_c && (idx_q == IDX_W'(3));
    idx_d     = tick_c ? idx_q + IDX_W'(1) : idx_q;
    snap_d    = (wrap_c && !hold) ? {num1, num2} : snap_q;

    nibble_c  = '0;
    case (idx_d)
      2'd0:    nibble_c = snap_d[15:12];
      2'd1:    nibble_c = snap_d[11:8];
      2'd2:    nibble_c = snap_d[7:4];
      default: nibble_c = snap_d[3:0];
    endcase

    // Only the high nibble of each byte (even slots) is blanked.
    seg_low_c = (blank_lz && !idx_d[0] && (nibble_c == '0)) ? SEG_OFF_LOW : hex_c;
    seg_out_c = SEG_ACTIVE_LOW ? seg_low_c : ~seg_low_c;

    dp_on_c   = (idx_d == IDX_W'(1)) && dp_en;
    dp_out_c  = SEG_ACTIVE_LOW ? ~dp_on_c : dp_on_c;
  end

  // State and output registers; display outputs change only on a tick.
  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      idx_q      <= IDX_W'(3);
      snap_q     <= '0;
      an         <= AN_NONE;
      seg        <= SEG_OFF_OUT;
      dp         <= DP_OFF_OUT;
      frame_done <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      frame_done <= wrap_c;
      if (tick_c) begin
        an  <= AN_ONEHOT[idx_d];
        seg <= seg_out_c;
        dp  <= dp_out_c;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (CLK_DIV=4, active-low segments).
// The reference model derives the expected display from the number of clock
// edges since reset release: every 4th edge starts a new slot, every 4th slot
// starts a frame whose digits come from the inputs seen on that edge.
module tb_seg_scan_driver;

  logic       clk2;
  logic       reset;
  logic [7:0] num1, num2;
  logic       hold, blank_lz, dp_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  seg_scan_driver #(.CLK_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk2       (clk2),
    .reset      (reset),
    .num1       (num1),
    .num2       (num2),
    .hold       (hold),
    .blank_lz   (blank_lz),
    .dp_en      (dp_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  // Glyphs for 0..F, active-low {g,f,e,d,c,b,a}.
  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int tests = 0;
  int fails = 0;

  // Reference model state
  int          e;          // edges since reset release
  logic [15:0] msnap;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic        exp_fd;
  int          fd_count;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, expv, e);
    end
  endtask

  task automatic model_reset();
    e       = 0;
    msnap   = 16'h0000;
    exp_an  = 4'b1111;
    exp_seg = 7'h7F;
    exp_dp  = 1'b1;
    exp_fd  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".an"},  16'(an),         16'(exp_an));
    check({tag, ".seg"}, 16'(seg),        16'(exp_seg));
    check({tag, ".dp"},  16'(dp),         16'(exp_dp));
    check({tag, ".fd"},  16'(frame_done), 16'(exp_fd));
  endtask

  // One clock edge: advance the model from the inputs present at the edge,
  // then compare just after the edge.
  task automatic step();
    int t, sidx;
    logic [3:0] nib;
    @(posedge clk2);
    e++;
    exp_fd = 1'b0;
    if (e % 4 == 0) begin
      t    = e / 4;
      sidx = (t - 1) % 4;
      if (sidx == 0) begin
        exp_fd = 1'b1;
        if (!hold) msnap = {num1, num2};
      end
      case (sidx)
        0:       nib = msnap[15:12];
        1:       nib = msnap[11:8];
        2:       nib = msnap[7:4];
        default: nib = msnap[3:0];
      endcase
      exp_an  = ~(4'b1000 >> sidx);
      exp_seg = (blank_lz && (sidx % 2 == 0) && nib == 4'h0) ? 7'h7F : glyph[nib];
      exp_dp  = !((sidx == 1) && dp_en);
    end
    #1;
    check_all("model");
    if (frame_done === 1'b1) fd_count++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset    = 1'b0;
    num1     = 8'h35;
    num2     = 8'hA8;
    hold     = 1'b0;
    blank_lz = 1'b0;
    dp_en    = 1'b0;
    fd_count = 0;
    model_reset();

    // Reset state
    #12;
    check_all("reset");
    @(negedge clk2);
    reset = 1'b1;

    // Release: three idle edges, then first slot with frame_done
    run(3);
    check("rel.an_idle", 16'(an), 16'h000F);
    run(1);
    check("rel.an_first", 16'(an), 16'h0007);
    check("rel.fd_pulse", 16'(frame_done), 16'h0001);
    check("scan.slot0", 16'(seg), 16'h0030);
    run(1);
    check("rel.fd_single", 16'(frame_done), 16'h0000);
    run(3);
    check("scan.slot1", {5'd0, an, seg}, {5'd0, 4'b1011, 7'h12});
    run(4);
    check("scan.slot2", {5'd0, an, seg}, {5'd0, 4'b1101, 7'h08});
    run(4);
    check("scan.slot3", {5'd0, an, seg}, {5'd0, 4'b1110, 7'h00});

    // Snapshot coherency: change num1 during idx=1 of the next frame
    run(8);            // e=24, idx1 slot
    run(1);
    num1 = 8'hF1;
    run(3);            // e=28
    check("coh.idx2", 16'(seg), 16'h0008);
    run(4);            // e=32
    check("coh.idx3", 16'(seg), 16'h0000);
    run(4);            // e=36
    check("coh.next0", 16'(seg), 16'h000E);
    run(4);            // e=40
    check("coh.next1", 16'(seg), 16'h0079);

    // Hold across two wraps with changing inputs
    hold     = 1'b1;
    fd_count = 0;
    for (int i = 0; i < 32; i++) begin
      num1 = 8'($urandom);
      num2 = 8'($urandom);
      step();
    end
    check("hold.fd_count", 16'(fd_count), 16'd2);
    hold = 1'b0;

    // Blanking and decimal point (e=72, next wrap at 84)
    num1     = 8'h05;
    num2     = 8'h00;
    blank_lz = 1'b1;
    dp_en    = 1'b1;
    run(12);
    check("blank.idx0", {8'd0, dp, seg}, {8'd0, 1'b1, 7'h7F});
    run(4);
    check("blank.idx1", {8'd0, dp, seg}, {8'd0, 1'b0, 7'h12});
    run(4);
    check("blank.idx2", {8'd0, dp, seg}, {8'd0, 1'b1, 7'h7F});
    run(4);
    check("blank.idx3", {8'd0, dp, seg}, {8'd0, 1'b1, 7'h40});

    // Randomized inputs, changing every cycle, including mid-slot changes
    for (int i = 0; i < 320; i++) begin
      num1     = 8'($urandom);
      num2     = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      hold     = ($urandom_range(0, 3) == 0);
      blank_lz = 1'($urandom);
      dp_en    = 1'($urandom);
      step();
    end
    hold = 1'b0;

    // Reach idx=2 with prescaler=1 (edge count 13 mod 16), bounded
    for (int i = 0; i < 16 && (e % 16) != 13; i++) step();
    check("mid.position", 16'(e % 16), 16'd13);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("mid.async");
    @(negedge clk2);
    reset = 1'b1;
    num1  = 8'h3C;
    num2  = 8'hD0;
    run(4);
    check("mid.restart_an", 16'(an), 16'h0007);
    check("mid.restart_fd", 16'(frame_done), 16'h0001);
    run(16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
